cpa_share_arbiter: RTL and testbench

//  Shares one combinational WIDTH-bit carry-propagate adder (addercpa4-class, S = A+B, no carry-out)

---
 rtl/cpa_share_arbiter.sv | 76 +++++++
 tb/tb_cpa_share_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/cpa_share_arbiter.sv
// Two-requester front end for one shared combinational adder: round-robin grant,
// operand latching, one issue cycle, then a held result until the consumer takes it.
module cpa_share_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_s,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    input  logic             rsp_ready
);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t state;
    logic   last_grant;
    logic   pick0, pick1;

    // On a tie the requester that did not win last time goes next.
    always_comb begin
        pick0      = req0_valid && (!req1_valid || last_grant);
        pick1      = req1_valid && (!req0_valid || !last_grant);
        req0_ready = rst_n && (state == IDLE) && pick0;
        req1_ready = rst_n && (state == IDLE) && pick1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            add_a      <= '0;
            add_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            last_grant <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (pick0 || pick1) begin
                        add_a      <= pick1 ? req1_a : req0_a;
                        add_b      <= pick1 ? req1_b : req0_b;
                        rsp_id     <= pick1;
                        last_grant <= pick1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Operands have been stable on the adder for a full cycle.
                    rsp_sum   <= add_s;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpa_share_arbiter.sv
// Randomized + directed bench for cpa_share_arbiter against a transaction-level model
// (one outstanding op, accept cycle + 2 for the response, alternate on ties).
module tb_cpa_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_ready, req1_ready;
    logic [3:0] add_a, add_b, add_s;
    logic       rsp_valid, rsp_id;
    logic [3:0] rsp_sum;
    logic       rsp_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: one op in flight at most.
    bit         m_busy, m_last, m_id;
    int         m_acc, cyc;
    logic [3:0] m_a, m_b, m_sum;
    logic       o_r0, o_r1;

    always #5 clk = ~clk;

    // The shared adder itself lives outside the block.
    assign add_s = add_a + add_b;

    cpa_share_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .add_a(add_a), .add_b(add_b), .add_s(add_s),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_busy = 0; m_last = 1; m_id = 0; m_acc = 0;
        m_a = '0; m_b = '0; m_sum = '0;
    endfunction

    // Assert reset mid-cycle, check outputs drop at once, release with no requests pending.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        #1;
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_id"}, rsp_id, 0);
        chk({tag, "_rsp_sum"}, rsp_sum, 0);
        chk({tag, "_add_a"}, add_a, 0);
        chk({tag, "_add_b"}, add_b, 0);
        chk({tag, "_ready"}, {req1_ready, req0_ready}, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic cycle(input logic v0, input logic [3:0] a0, input logic [3:0] b0,
                         input logic v1, input logic [3:0] a1, input logic [3:0] b1,
                         input logic rr);
        bit e_r0, e_r1, e_vld, win;
        @(negedge clk);
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        rsp_ready  = rr;
        #1;
        o_r0 = req0_ready; o_r1 = req1_ready;
        // Exactly one valid wins outright; a tie goes to the one not granted last.
        win   = (v0 && v1) ? !m_last : v1;
        e_r0  = !m_busy && (v0 || v1) && !win;
        e_r1  = !m_busy && (v0 || v1) && win;
        e_vld = m_busy && (cyc >= m_acc + 2);
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("one_ready", req0_ready & req1_ready, 0);
        chk("rsp_valid", rsp_valid, e_vld);
        chk("add_a", add_a, m_a);
        chk("add_b", add_b, m_b);
        if (e_vld) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_sum", rsp_sum, m_sum);
        end
        if (e_vld && rr) m_busy = 0;
        if (e_r0 || e_r1) begin
            m_busy = 1; m_acc = cyc; m_id = win; m_last = win;
            m_a    = win ? a1 : a0;
            m_b    = win ? b1 : b0;
            m_sum  = 4'((int'(m_a) + int'(m_b)) % 16);
        end
        cyc++;
    endtask

    initial begin
        int k;
        cyc = 0;
        model_reset();
        do_reset("t1_rst");

        // T1: lone requester 0
        cycle(1, 4, 2, 0, 0, 0, 1);
        cycle(0, 9, 9, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);
        chk("t1_sum_seen", m_sum, 4'd6);
        cycle(0, 0, 0, 0, 0, 0, 1);

        // T2: lone requester 1, back to back
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 8, 2, 1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, 1, 1);
        cycle(0, 0, 0, 0, 0, 0, 1);

        // T3: simultaneous after reset, wraparound sum on requester 1
        do_reset("t3_rst");
        for (int i = 0; i < 7; i++) cycle(1, 4, 8, 1, 15, 1, 1);

        // T4: both held valid, grants must alternate starting from 0
        do_reset("t4_rst");
        k = 0;
        for (int i = 0; i < 18; i++) begin
            cycle(1, 4'($urandom), 4'($urandom), 1, 4'($urandom), 4'($urandom), 1);
            if (o_r0 || o_r1) begin
                chk("t4_alt", o_r1, k % 2);
                k++;
            end
        end
        chk("t4_count", k, 6);

        // T5: consumer stalls 5 cycles in RESP
        do_reset("t5_rst");
        cycle(1, 7, 7, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 1, 2, 1, 3, 4, 0);
        cycle(1, 1, 2, 1, 3, 4, 1);
        cycle(1, 1, 2, 1, 3, 4, 1);
        chk("t5_next_accept", o_r1, 1);

        // T6: reset during ISSUE discards the op
        do_reset("t6_pre");
        cycle(1, 5, 5, 0, 0, 0, 1);
        do_reset("t6_mid");
        for (int i = 0; i < 6; i++) cycle(1, 2, 3, 1, 6, 6, 1);

        // Random traffic
        do_reset("rnd_rst");
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 2) != 0, 4'($urandom), 4'($urandom),
                  $urandom_range(0, 2) != 0, 4'($urandom), 4'($urandom),
                  $urandom_range(0, 3) != 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
